// File: rtl/gfx_pkg.sv
// Shared types and constants for the frame-buffer side of the graphics pipeline.
package gfx_pkg;

  localparam int DW = 32;
  localparam int BW = 4;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int REQ_FILL_RECT = 0;
  localparam int REQ_LINE      = 1;
  localparam int REQ_REFRESH   = 2;

endpackage

// File: rtl/frame_buf_arbiter_rr_grant.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping, when enabled; one-hot grant plus its index.
module rr_grant #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      // pointer + offset, folded back into 0..N-1 without a divider
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (en_i && !vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_buf_arbiter.sv
// Round-robin arbiter from N_REQ word requesters onto one single-port frame
// buffer; read data is steered back to the issuer through a tag pipeline.
import gfx_pkg::*;

module frame_buf_arbiter #(
  parameter int N_REQ  = 3,
  parameter int RD_LAT = 1,
  parameter int AW     = 16
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [DW*N_REQ-1:0] req_data,
  input  logic [AW*N_REQ-1:0] req_addr,
  input  logic [BW*N_REQ-1:0] req_wben,
  input  logic [N_REQ-1:0]    req_op,
  input  logic [N_REQ-1:0]    req_rts,
  output logic [N_REQ-1:0]    req_rtr,
  output logic [DW-1:0]       rd_data,
  output logic [N_REQ-1:0]    rd_valid,
  input  logic                mem_rdy,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic [BW-1:0]       mem_wben,
  input  logic [DW-1:0]       mem_rdata
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic              mem_en_q, mem_we_q;
  logic [AW-1:0]     mem_addr_q;
  logic [DW-1:0]     mem_wdata_q;
  logic [BW-1:0]     mem_wben_q;
  logic [IW-1:0]     cmd_idx_q;
  logic [IW-1:0]     ptr_q;
  logic [RD_LAT-1:0] tag_v_q;
  logic [IW-1:0]     tag_q [RD_LAT];
  logic [N_REQ-1:0]  rd_valid_q;
  logic [DW-1:0]     rd_data_q;

  logic              cmd_free;
  logic              gnt_vld;
  logic [IW-1:0]     gnt_idx;
  logic [N_REQ-1:0]  gnt;

  // The single command slot can be refilled in the same cycle it drains.
  assign cmd_free = ~mem_en_q | mem_rdy;

  rr_grant #(.N(N_REQ), .IW(IW)) u_rr_grant (
    .req_i (req_rts),
    .ptr_i (ptr_q),
    .en_i  (cmd_free),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (rst_) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wben_q  <= '0;
      cmd_idx_q   <= '0;
      ptr_q       <= '0;
      tag_v_q     <= '0;
      for (int k = 0; k < RD_LAT; k++) tag_q[k] <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
    end else begin
      if (gnt_vld) begin
        mem_en_q    <= 1'b1;
        mem_we_q    <= req_op[gnt_idx];
        mem_addr_q  <= req_addr[gnt_idx*AW +: AW];
        mem_wdata_q <= req_data[gnt_idx*DW +: DW];
        mem_wben_q  <= (req_op[gnt_idx] == OP_WRITE) ? req_wben[gnt_idx*BW +: BW] : '0;
        cmd_idx_q   <= gnt_idx;
        ptr_q       <= (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + IW'(1);
      end else if (mem_rdy) begin
        mem_en_q <= 1'b0;
      end

      tag_v_q[0] <= mem_en_q & mem_rdy & ~mem_we_q;
      tag_q[0]   <= cmd_idx_q;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_v_q[k] <= tag_v_q[k-1];
        tag_q[k]   <= tag_q[k-1];
      end

      rd_valid_q <= '0;
      if (tag_v_q[RD_LAT-1]) begin
        rd_valid_q[tag_q[RD_LAT-1]] <= 1'b1;
        rd_data_q                   <= mem_rdata;
      end
    end
  end

  assign req_rtr   = gnt;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wben  = mem_wben_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule
